id_hazard_controller: RTL

//  Drives the stall/flush controls consumed by the ID/EX pipeline register: id_shouldStall, exceptClear, eret_clearSignal.

---
 rtl/id_hazard_controller.sv | 106 ++++++++++
 1 files changed

// File: rtl/id_hazard_controller.sv
// ID-stage hazard and flush controller: RAW scoreboard over EX/MEM/WB,
// bubble insertion into ID/EX, and multi-cycle exception/ERET flush sequencing.
module id_hazard_controller #(
    parameter bit FORWARDING   = 1'b1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_en,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_useRs,
    input  logic             id_useRt,
    input  logic [4:0]       id_wrAddr,
    input  logic             id_wrEn,
    input  logic             id_isLoad,
    input  logic             exc_req,
    input  logic             eret_req,
    output logic             id_shouldStall,
    output logic             pc_hold,
    output logic             exceptClear,
    output logic             eret_clearSignal,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {IDLE, EXC_FLUSH, ERET_FLUSH} state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] addr;
        logic       load;
    } sb_t;

    localparam logic [3:0] RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam bit MULTI = (FLUSH_CYCLES > 1);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    sb_t        sb0, sb1, sb2;
    sb_t        issue_e;
    logic       idle, hit, hit_ex, hit_mem, stall_raw, issue;

    function automatic logic src_hit(sb_t e, logic [4:0] src, logic used);
        return used && src != 5'd0 && e.valid && e.addr == src;
    endfunction

    always_comb begin
        hit_ex  = src_hit(sb0, id_rs, id_useRs) | src_hit(sb0, id_rt, id_useRt);
        hit_mem = src_hit(sb1, id_rs, id_useRs) | src_hit(sb1, id_rt, id_useRt);
        hit     = FORWARDING ? (hit_ex & sb0.load) : (hit_ex | hit_mem);
        idle    = (state == IDLE);
        stall_raw = id_valid & hit & idle & ~exc_req & ~eret_req;
        issue   = id_valid & id_wrEn & (id_wrAddr != 5'd0) & ~stall_raw
                & idle & ~exc_req & ~eret_req;
        issue_e = '{valid: issue, addr: id_wrAddr, load: id_isLoad};
    end

    // Outputs are forced low during reset even if request pulses arrive.
    always_comb begin
        id_shouldStall   = ~rst & stall_raw;
        pc_hold          = ~rst & stall_raw;
        exceptClear      = ~rst & (exc_req | state == EXC_FLUSH);
        eret_clearSignal = ~rst & ((eret_req & ~exc_req & state != EXC_FLUSH)
                         | state == ERET_FLUSH);
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (exc_req) begin
            state_n = MULTI ? EXC_FLUSH : IDLE;
            cnt_n   = RELOAD;
        end else if (state == EXC_FLUSH) begin
            if (cnt <= 4'd1) state_n = IDLE;
            cnt_n = cnt - 4'd1;
        end else if (eret_req) begin
            state_n = MULTI ? ERET_FLUSH : IDLE;
            cnt_n   = RELOAD;
        end else if (state == ERET_FLUSH) begin
            if (cnt <= 4'd1) state_n = IDLE;
            cnt_n = cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            sb0         <= '0;
            sb1         <= '0;
            sb2         <= '0;
            stall_count <= '0;
        end else if (cpu_en) begin
            state <= state_n;
            cnt   <= cnt_n;
            sb2   <= sb1;
            sb1   <= sb0;
            sb0   <= issue_e;
            if (stall_raw && !(&stall_count))
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule
